// File: rtl/alu_exec_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_if
//  Description : Request/result bundle between the operand-mux stage and the
//                execute-stage ALU. The master drives the request, the slave
//                (the ALU) returns the registered result, flags and handshake.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_exec_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_s;
    logic             flag_c;
    logic             flag_v;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, src,
        input  result, flag_z, flag_s, flag_c, flag_v, busy, done
    );

    modport slave (
        input  start, op, a, src,
        output result, flag_z, flag_s, flag_c, flag_v, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec
//  Description : 16-bit execute-stage ALU. Add/sub/logic/move/compare finish
//                in one cycle; shifts run on a 1-bit-per-cycle shifter with a
//                busy/done handshake. Result and NZCV flags are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_exec #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    alu_exec_if.slave   bus
);

    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_SUB = 4'd1;
    localparam logic [3:0] c_OP_AND = 4'd2;
    localparam logic [3:0] c_OP_OR  = 4'd3;
    localparam logic [3:0] c_OP_XOR = 4'd4;
    localparam logic [3:0] c_OP_NOT = 4'd5;
    localparam logic [3:0] c_OP_MOV = 4'd6;
    localparam logic [3:0] c_OP_CMP = 4'd7;
    localparam logic [3:0] c_OP_SLL = 4'd8;
    localparam logic [3:0] c_OP_SRL = 4'd9;
    localparam logic [3:0] c_OP_SRA = 4'd10;

    localparam logic [SHAMT_W-1:0] c_ONE = SHAMT_W'(1);

    // Shift kind is op[1:0] for the three shift codes: 00 SLL, 01 SRL, 10 SRA
    localparam logic [1:0] c_K_SLL = 2'b00;
    localparam logic [1:0] c_K_SRL = 2'b01;
    localparam logic [1:0] c_K_SRA = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_cnt;
    logic [1:0]         r_kind;
    logic [WIDTH-1:0]   r_result;
    logic               r_z;
    logic               r_s;
    logic               r_c;
    logic               r_v;
    logic               r_busy;
    logic               r_done;

    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_dif;
    logic               w_add_v;
    logic               w_sub_v;
    logic [WIDTH:0]     w_first;
    logic [WIDTH:0]     w_step;
    logic               w_is_shift;
    logic               w_long;
    logic [WIDTH-1:0]   w_val;
    logic               w_c;
    logic               w_v;
    logic               w_wr_res;
    logic               w_wr_flg;

    // One shifter step: returns {bit shifted out, shifted value}
    function automatic logic [WIDTH:0] shift_once(input logic [1:0] kind,
                                                   input logic [WIDTH-1:0] v);
        logic [WIDTH:0] r;
        case (kind)
            c_K_SLL: r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            c_K_SRL: r = {v[0], 1'b0, v[WIDTH-1:1]};
            c_K_SRA: r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            default: r = {1'b0, v};
        endcase
        return r;
    endfunction

    assign w_shamt    = bus.src[SHAMT_W-1:0];
    assign w_sum      = {1'b0, bus.a} + {1'b0, bus.src};
    // Top bit of the 17-bit difference is the borrow: set iff a < src unsigned
    assign w_dif      = {1'b0, bus.a} - {1'b0, bus.src};
    assign w_add_v    = (bus.a[WIDTH-1] == bus.src[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
    assign w_sub_v    = (bus.a[WIDTH-1] != bus.src[WIDTH-1]) &&
                        (w_dif[WIDTH-1] != bus.a[WIDTH-1]);
    assign w_first    = shift_once(bus.op[1:0], bus.a);
    assign w_step     = shift_once(r_kind, r_work);
    assign w_is_shift = (bus.op == c_OP_SLL) || (bus.op == c_OP_SRL) ||
                        (bus.op == c_OP_SRA);
    // Shifts of 0 or 1 bit complete in the accepting cycle like any other op
    assign w_long     = w_is_shift && (w_shamt > c_ONE);

    // Single-cycle datapath: value, C/V and which registers the op updates
    always_comb begin
        w_val    = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        w_wr_res = 1'b0;
        w_wr_flg = 1'b0;
        case (bus.op)
            c_OP_ADD: begin
                w_val    = w_sum[WIDTH-1:0];
                w_c      = w_sum[WIDTH];
                w_v      = w_add_v;
                w_wr_res = 1'b1;
                w_wr_flg = 1'b1;
            end
            c_OP_SUB: begin
                w_val    = w_dif[WIDTH-1:0];
                w_c      = w_dif[WIDTH];
                w_v      = w_sub_v;
                w_wr_res = 1'b1;
                w_wr_flg = 1'b1;
            end
            c_OP_AND, c_OP_OR, c_OP_XOR, c_OP_NOT, c_OP_MOV: begin
                case (bus.op)
                    c_OP_AND: w_val = bus.a & bus.src;
                    c_OP_OR:  w_val = bus.a | bus.src;
                    c_OP_XOR: w_val = bus.a ^ bus.src;
                    c_OP_NOT: w_val = ~bus.a;
                    default:  w_val = bus.src;
                endcase
                w_wr_res = 1'b1;
                w_wr_flg = 1'b1;
            end
            c_OP_CMP: begin
                w_val    = w_dif[WIDTH-1:0];
                w_c      = w_dif[WIDTH];
                w_v      = w_sub_v;
                w_wr_flg = 1'b1;
            end
            c_OP_SLL, c_OP_SRL, c_OP_SRA: begin
                if (w_shamt == '0) begin
                    w_val = bus.a;
                    w_c   = 1'b0;
                end else begin
                    w_val = w_first[WIDTH-1:0];
                    w_c   = w_first[WIDTH];
                end
                w_wr_res = 1'b1;
                w_wr_flg = 1'b1;
            end
            default: begin
                // Reserved codes leave result and flags untouched
                w_wr_res = 1'b0;
                w_wr_flg = 1'b0;
            end
        endcase
    end

    // Control FSM, shifter and registered result/flags/handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_work   <= '0;
            r_cnt    <= '0;
            r_kind   <= '0;
            r_result <= '0;
            r_z      <= 1'b0;
            r_s      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (w_long) begin
                            // First shift happens on the accepting edge
                            r_work  <= w_first[WIDTH-1:0];
                            r_cnt   <= w_shamt - c_ONE;
                            r_kind  <= bus.op[1:0];
                            r_busy  <= 1'b1;
                            r_state <= ST_SHIFT;
                        end else begin
                            r_done <= 1'b1;
                            if (w_wr_res) begin
                                r_result <= w_val;
                            end
                            if (w_wr_flg) begin
                                r_z <= (w_val == '0);
                                r_s <= w_val[WIDTH-1];
                                r_c <= w_c;
                                r_v <= w_v;
                            end
                        end
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_step[WIDTH-1:0];
                    r_cnt  <= r_cnt - c_ONE;
                    if (r_cnt == c_ONE) begin
                        r_result <= w_step[WIDTH-1:0];
                        r_z      <= (w_step[WIDTH-1:0] == '0);
                        r_s      <= w_step[WIDTH-1];
                        r_c      <= w_step[WIDTH];
                        r_v      <= 1'b0;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.flag_z = r_z;
    assign bus.flag_s = r_s;
    assign bus.flag_c = r_c;
    assign bus.flag_v = r_v;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec
//  Description : Scoreboard bench for alu_exec. Each accepted request pushes
//                its expected result, flags, completion cycle and busy length;
//                every done pulse pops and compares one entry.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_exec;

    typedef struct packed {
        logic [15:0] r;
        logic        z;
        logic        s;
        logic        c;
        logic        v;
    } exp_t;

    typedef struct {
        exp_t e;
        int   done_cyc;
        int   busy_cyc;
    } sb_item_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   busy_cnt;
    exp_t last;
    sb_item_t sb[$];

    alu_exec_if #(.WIDTH(16)) bus ();

    alu_exec #(.WIDTH(16), .SHAMT_W(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model, written independently of the shifter structure
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] src, input exp_t prev);
        exp_t        e;
        logic [15:0] val;
        int          n;
        int          sa;
        int          ss;
        int          t;
        n   = int'(src[3:0]);
        sa  = int'($signed(a));
        ss  = int'($signed(src));
        e   = prev;
        val = '0;
        e.c = 1'b0;
        e.v = 1'b0;
        case (op)
            4'd0: begin
                val = a + src;
                e.c = ((int'(a) + int'(src)) > 65535);
                t   = sa + ss;
                e.v = (t > 32767) || (t < -32768);
            end
            4'd1, 4'd7: begin
                val = a - src;
                e.c = (a < src);
                t   = sa - ss;
                e.v = (t > 32767) || (t < -32768);
            end
            4'd2: val = a & src;
            4'd3: val = a | src;
            4'd4: val = a ^ src;
            4'd5: val = ~a;
            4'd6: val = src;
            4'd8: begin
                val = a << n;
                e.c = (n == 0) ? 1'b0 : a[16-n];
            end
            4'd9: begin
                val = a >> n;
                e.c = (n == 0) ? 1'b0 : a[n-1];
            end
            4'd10: begin
                val = $signed(a) >>> n;
                e.c = (n == 0) ? 1'b0 : a[n-1];
            end
            default: return prev;
        endcase
        e.z = (val == 16'h0000);
        e.s = val[15];
        e.r = (op == 4'd7) ? prev.r : val;
        return e;
    endfunction

    // Drive one request at the current negedge; returns one cycle later
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] src);
        sb_item_t it;
        int       n;
        int       lat;
        n    = int'(src[3:0]);
        it.e = model(op, a, src, last);
        last = it.e;
        lat  = (op >= 4'd8 && op <= 4'd10 && n >= 2) ? n : 1;
        it.done_cyc = cyc + lat;
        it.busy_cyc = lat - 1;
        sb.push_back(it);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.src   = src;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 4'($urandom);
        bus.a     = 16'($urandom);
        bus.src   = 16'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!bus.done && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!bus.done) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Output monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        sb_item_t it;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    it = sb.pop_front();
                    check("result", 32'(bus.result), 32'(it.e.r));
                    check("flags_zscv", 32'({bus.flag_z, bus.flag_s, bus.flag_c, bus.flag_v}),
                          32'({it.e.z, it.e.s, it.e.c, it.e.v}));
                    check("latency", 32'(cyc), 32'(it.done_cyc));
                    check("busy_cycles", 32'(busy_cnt), 32'(it.busy_cyc));
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        busy_cnt  = 0;
        last      = '0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 4'd0;
        bus.a     = 16'h0000;
        bus.src   = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_flags", 32'({bus.flag_z, bus.flag_s, bus.flag_c, bus.flag_v}), 32'd0);
        check("rst_busy_done", 32'({bus.busy, bus.done}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Arithmetic corner cases
        issue(4'd0, 16'h7FFF, 16'h0001);
        issue(4'd1, 16'h0000, 16'h0001);
        issue(4'd7, 16'h1234, 16'h1234);
        wait_idle();

        // Long arithmetic shift, then a one-bit logical shift
        issue(4'd10, 16'h8000, 16'h000F);
        wait_idle();
        issue(4'd9, 16'h8001, 16'h0001);
        issue(4'd8, 16'h0001, 16'hFFF0);
        issue(4'd0, 16'hFFFF, 16'h0001);
        issue(4'd1, 16'h8000, 16'h0001);
        issue(4'd13, 16'h5555, 16'h5555);
        wait_idle();

        // Random mix including reserved codes
        for (int i = 0; i < 16; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            issue(op, 16'($urandom), 16'($urandom));
            if (op >= 4'd8 && op <= 4'd10) wait_idle();
        end
        wait_idle();

        // Start while busy is ignored; start in the done cycle is accepted
        issue(4'd8, 16'h0003, 16'h000A);
        repeat (2) @(negedge clk);
        check("busy_mid_shift", 32'(bus.busy), 32'd1);
        bus.start = 1'b1;
        bus.op    = 4'd0;
        bus.a     = 16'h1111;
        bus.src   = 16'h2222;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        issue(4'd4, 16'hF0F0, 16'h0FF1);
        wait_idle();

        // Reset aborts a 12-bit shift with no done pulse
        issue(4'd9, 16'hFFFF, 16'h000C);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_result", 32'(bus.result), 32'd0);
        check("abort_flags", 32'({bus.flag_z, bus.flag_s, bus.flag_c, bus.flag_v}), 32'd0);
        check("abort_busy_done", 32'({bus.busy, bus.done}), 32'd0);
        sb.delete();
        last = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (16) @(negedge clk);
        check("abort_idle_busy", 32'(bus.busy), 32'd0);
        issue(4'd6, 16'h0000, 16'hA5A5);
        wait_idle();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
